// File: rtl/conv_code_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional code.
package conv_code_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned DATA_W_DEF = 8;
    localparam logic [K-1:0] G0_DEF    = 3'b111;
    localparam logic [K-1:0] G1_DEF    = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        HOLD   = 2'd2
    } enc_state_e;

endpackage

// File: rtl/conv_encoder_r12_if.sv
// Message-in / code-word-out handshake bundle for conv_encoder_r12.
interface conv_encoder_r12_if
    import conv_code_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );

endinterface

// File: rtl/conv_enc_step.sv
// One trellis step of the K=3 encoder: (b, s1, s2) -> (g0, g1, next s1, next s2).
module conv_enc_step
    import conv_code_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic b_i,
    input  logic s1_i,
    input  logic s2_i,
    output logic g0_c,
    output logic g1_c,
    output logic s1_nxt_c,
    output logic s2_nxt_c
);

    logic [K-1:0] taps;

    // Parity of the tapped register contents, then advance the shift state.
    always_comb begin
        taps     = {b_i, s1_i, s2_i};
        g0_c     = ^(taps & G0);
        g1_c     = ^(taps & G1);
        s1_nxt_c = b_i;
        s2_nxt_c = s1_i;
    end

endmodule

// File: rtl/conv_encoder_r12.sv
// Rate-1/2, K=3 convolutional encoder: one message word in, one code word out,
// encoded serially MSB-first.
// Build option: CONV_ENC_STATE_CARRY_EN keeps {s1,s2} across words (stream code);
// by default the trellis state is cleared whenever a word is accepted.
module conv_encoder_r12
    import conv_code_pkg::*;
#(
    parameter int unsigned  DATA_W = DATA_W_DEF,
    parameter logic [K-1:0] G0     = G0_DEF,
    parameter logic [K-1:0] G1     = G1_DEF
) (
    input  logic              clk,
    input  logic              rst,
    conv_encoder_r12_if.slave bus
);

    localparam int unsigned CODE_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    enc_state_e          state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CODE_W-1:0]   code_q,  code_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                s1_q,    s1_d;
    logic                s2_q,    s2_d;
    logic                in_ready_q,  in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic g0, g1, s1_nxt, s2_nxt;

    conv_enc_step #(
        .G0 (G0),
        .G1 (G1)
    ) u_step (
        .b_i      (shreg_q[DATA_W-1]),
        .s1_i     (s1_q),
        .s2_i     (s2_q),
        .g0_c     (g0),
        .g1_c     (g1),
        .s1_nxt_c (s1_nxt),
        .s2_nxt_c (s2_nxt)
    );

    // Next-state and next-output logic; outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        s2_d    = s2_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    shreg_d = bus.data_in;
                    cnt_d   = '0;
`ifndef CONV_ENC_STATE_CARRY_EN
                    s1_d    = 1'b0;
                    s2_d    = 1'b0;
`endif
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                // Pairs enter at the LSB end so the first pair lands at the MSBs.
                code_d  = {code_q[CODE_W-3:0], g0, g1};
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                s1_d    = s1_nxt;
                s2_d    = s2_nxt;
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            code_q      <= '0;
            cnt_q       <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = code_q;

endmodule

// File: tb/tb_conv_encoder_r12.sv
// Directed self-checking bench for conv_encoder_r12 (DATA_W=8, G0=111, G1=101).
module tb_conv_encoder_r12;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

`ifdef CONV_ENC_STATE_CARRY_EN
    localparam logic [15:0] EXP_00_AFTER_FF = 16'h7000;
`else
    localparam logic [15:0] EXP_00_AFTER_FF = 16'h0000;
`endif

    conv_encoder_r12_if #(.DATA_W(8)) bus ();

    conv_encoder_r12 #(
        .DATA_W (8),
        .G0     (3'b111),
        .G1     (3'b101)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer a word until accepted; acc is the cycle count just after the accepting edge.
    task automatic drive_word(input logic [7:0] w, output int acc, output bit ok);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data_in  = w;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 40);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until out_valid is seen at a falling edge.
    task automatic wait_valid(output int seen, output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok   = (n < 40);
        seen = cyc;
    endtask

    // Take the code word in one cycle; called from a falling edge.
    task automatic deliver();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.data_out !== 16'h0000) begin
            errors++; $display("FAIL reset_data_out: got %h expected 0000", bus.data_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_b0();
        int acc, seen;
        bit ok;
        drive_word(8'hB0, acc, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b0_accept: got timeout expected accept"); end
        wait_valid(seen, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b0_valid: got timeout expected out_valid"); end
        checks++;
        if (seen - acc !== 8) begin
            errors++; $display("FAIL b0_latency: got %0d expected 8", seen - acc);
        end
        checks++;
        if (bus.data_out !== 16'hE170) begin
            errors++; $display("FAIL b0_data: got %h expected e170", bus.data_out);
        end
        deliver();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b0_release: got valid=%b ready=%b expected valid=0 ready=1",
                               bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_ff_then_00();
        int acc, seen;
        bit ok;
        drive_word(8'hFF, acc, ok);
        wait_valid(seen, ok);
        checks++;
        if (!ok || bus.data_out !== 16'hDAAA) begin
            errors++; $display("FAIL ff_data: got %h ok=%b expected daaa", bus.data_out, ok);
        end
        deliver();
        drive_word(8'h00, acc, ok);
        wait_valid(seen, ok);
        checks++;
        if (!ok || bus.data_out !== EXP_00_AFTER_FF) begin
            errors++; $display("FAIL zero_after_ff: got %h ok=%b expected %h",
                               bus.data_out, ok, EXP_00_AFTER_FF);
        end
        deliver();
    endtask

    task automatic test_backpressure();
        int acc, seen;
        bit ok;
        int bad_data = 0, bad_valid = 0, bad_ready = 0, bad_idle = 0;
        bus.out_ready = 1'b0;
        drive_word(8'hB0, acc, ok);
        wait_valid(seen, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_valid: got timeout expected out_valid"); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.data_in  = 8'h5A;
            if (bus.data_out !== 16'hE170) bad_data++;
            if (bus.out_valid !== 1'b1)    bad_valid++;
            if (bus.in_ready !== 1'b0)     bad_ready++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad_data != 0) begin
            errors++; $display("FAIL bp_data_stable: got %0d bad cycles expected 0", bad_data);
        end
        checks++;
        if (bad_valid != 0) begin
            errors++; $display("FAIL bp_valid_held: got %0d bad cycles expected 0", bad_valid);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++; $display("FAIL bp_in_ready_low: got %0d bad cycles expected 0", bad_ready);
        end
        deliver();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1",
                               bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad_idle++;
        end
        checks++;
        if (bad_idle != 0) begin
            errors++; $display("FAIL bp_pulses_ignored: got %0d non-idle cycles expected 0", bad_idle);
        end
    endtask

    task automatic test_reset_mid_encode();
        int acc, seen;
        bit ok;
        int rose = 0;
        drive_word(8'hB0, acc, ok);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.data_out !== 16'h0000) begin
            errors++; $display("FAIL midrst_state: got ready=%b valid=%b data=%h expected 1 0 0000",
                               bus.in_ready, bus.out_valid, bus.data_out);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) rose++;
        end
        checks++;
        if (rose != 0) begin
            errors++; $display("FAIL midrst_no_output: got %0d valid cycles expected 0", rose);
        end
        drive_word(8'hB0, acc, ok);
        wait_valid(seen, ok);
        checks++;
        if (!ok || bus.data_out !== 16'hE170) begin
            errors++; $display("FAIL midrst_next_word: got %h ok=%b expected e170", bus.data_out, ok);
        end
        deliver();
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, seen;
        bit ok;
        bus.out_ready = 1'b1;
        drive_word(8'hFF, acc_a, ok);
        wait_valid(seen, ok);
        checks++;
        if (!ok || bus.data_out !== 16'hDAAA) begin
            errors++; $display("FAIL b2b_first: got %h ok=%b expected daaa", bus.data_out, ok);
        end
        drive_word(8'h00, acc_b, ok);
        checks++;
        if (acc_b - acc_a !== 10) begin
            errors++; $display("FAIL b2b_cadence: got %0d cycles expected 10", acc_b - acc_a);
        end
        wait_valid(seen, ok);
        checks++;
        if (!ok || bus.data_out !== EXP_00_AFTER_FF) begin
            errors++; $display("FAIL b2b_second: got %h ok=%b expected %h",
                               bus.data_out, ok, EXP_00_AFTER_FF);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got ready=%b valid=%b expected 1 0",
                               bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_b0();
        test_ff_then_00();
        test_backpressure();
        test_reset_mid_encode();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
